// File: rtl/upload_packer.sv
// upload_packer
//   Consumer end of the handler upload interface. Collects one packet of
//   payload bytes (req held high for the whole packet, bytes on valid/ready),
//   buffers and counts them, then emits a framed packet byte-by-byte:
//     HDR0, HDR1, source, len_hi, len_lo, payload[0..N-1], checksum
//   checksum = (source + len_hi + len_lo + sum(payload)) mod 256.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   upload_req           high for the duration of a packet
//   upload_data/_source  payload byte / packet source ID
//   upload_valid/_ready  payload byte handshake
//   tx_data/_valid/_ready framed output byte stream
//   busy                 not IDLE
//   overflow             sticky: a byte was dropped because the buffer was full
module upload_packer #(
  parameter int         FIFO_DEPTH = 256,
  parameter logic [7:0] HDR0       = 8'hAA,
  parameter logic [7:0] HDR1       = 8'h44
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upload_req,
  input  logic [7:0] upload_data,
  input  logic [7:0] upload_source,
  input  logic       upload_valid,
  output logic       upload_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DEPTH16 = FIFO_DEPTH[15:0];

  typedef enum logic [3:0] {
    IDLE, COLLECT, S_H0, S_H1, S_SRC, S_LENH, S_LENL, S_DATA, S_SUM
  } state_t;

  state_t          r_state, w_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [15:0]     r_cnt, w_cnt_nxt;
  logic [7:0]      r_sum, r_src, r_tx_data, w_ld_byte;
  logic            r_ovf;
  // Held low for the first cycle after reset so upload_ready comes out of
  // reset at 0 even though IDLE with an empty buffer would otherwise be ready.
  logic            r_en;
  logic            w_accept, w_hs, w_pop, w_seed, w_clr, w_full;
  logic [7:0]      w_seed_sum;

  assign w_full       = (r_cnt == DEPTH16);
  assign upload_ready = r_en && (r_state == IDLE || r_state == COLLECT) && !w_full;
  assign w_accept     = upload_valid && upload_ready && (r_state == COLLECT || upload_req);
  assign w_cnt_nxt    = r_cnt + {15'd0, w_accept};
  assign tx_valid     = (r_state != IDLE) && (r_state != COLLECT);
  assign tx_data      = r_tx_data;
  assign busy         = (r_state != IDLE);
  assign overflow     = r_ovf;
  assign w_hs         = tx_valid && tx_ready;

  // Checksum seed includes a byte accepted in the same cycle req drops.
  assign w_seed_sum = r_sum + (w_accept ? upload_data : 8'd0) + r_src
                    + w_cnt_nxt[15:8] + w_cnt_nxt[7:0];

  // Next state and the byte to present next. tx_data is loaded on the
  // transition into each send state, so it is stable while tx_valid waits.
  always_comb begin
    w_nxt     = r_state;
    w_ld_byte = r_tx_data;
    w_pop     = 1'b0;
    w_seed    = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      IDLE:    if (upload_req) w_nxt = COLLECT;
      COLLECT: if (!upload_req) begin
        if (w_cnt_nxt == 16'd0) w_nxt = IDLE;
        else begin
          w_nxt     = S_H0;
          w_seed    = 1'b1;
          w_ld_byte = HDR0;
        end
      end
      S_H0:   if (w_hs) begin w_nxt = S_H1;   w_ld_byte = HDR1;         end
      S_H1:   if (w_hs) begin w_nxt = S_SRC;  w_ld_byte = r_src;        end
      S_SRC:  if (w_hs) begin w_nxt = S_LENH; w_ld_byte = r_cnt[15:8];  end
      S_LENH: if (w_hs) begin w_nxt = S_LENL; w_ld_byte = r_cnt[7:0];   end
      // r_cnt counts bytes still in the buffer; it is at least 1 here.
      S_LENL: if (w_hs) begin
        w_nxt     = S_DATA;
        w_ld_byte = r_mem[r_rd];
        w_pop     = 1'b1;
      end
      S_DATA: if (w_hs) begin
        if (r_cnt != 16'd0) begin
          w_ld_byte = r_mem[r_rd];
          w_pop     = 1'b1;
        end else begin
          w_nxt     = S_SUM;
          w_ld_byte = r_sum;
        end
      end
      S_SUM:  if (w_hs) begin w_nxt = IDLE; w_clr = 1'b1; end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Payload storage; contents need no reset, pointers do.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr] <= upload_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_src     <= '0;
      r_tx_data <= '0;
      r_ovf     <= 1'b0;
      r_en      <= 1'b0;
    end else begin
      r_en      <= 1'b1;
      r_tx_data <= w_ld_byte;
      if (r_state == IDLE && upload_req) r_src <= upload_source;
      if (w_accept) r_wr <= r_wr + 1'b1;
      if (w_pop)    r_rd <= r_rd + 1'b1;
      if (w_clr)         r_cnt <= '0;
      else if (w_pop)    r_cnt <= r_cnt - 16'd1;
      else               r_cnt <= w_cnt_nxt;
      if (w_clr)         r_sum <= '0;
      else if (w_seed)   r_sum <= w_seed_sum;
      else if (w_accept) r_sum <= r_sum + upload_data;
      if (r_state == COLLECT && upload_valid && w_full) r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_upload_packer.sv
module tb_upload_packer;
  localparam int DEPTH = 4;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       upload_req = 1'b0, upload_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] upload_data = '0, upload_source = '0;
  logic       upload_ready, tx_valid, busy, overflow;
  logic [7:0] tx_data;

  upload_packer #(.FIFO_DEPTH(DEPTH), .HDR0(8'hAA), .HDR1(8'h44)) dut (
    .clk(clk), .rst_n(rst_n),
    .upload_req(upload_req), .upload_data(upload_data),
    .upload_source(upload_source), .upload_valid(upload_valid),
    .upload_ready(upload_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         n_tests = 0, n_fail = 0;
  bq_t        rxq;
  int         rdy_mode = 0, phase = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: stop at the negedge, pick tx_ready for the coming posedge,
  // record the byte that handshake will take, and check stall stability.
  task automatic tick();
    @(negedge clk);
    if (rst_n && prev_stall) begin
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
    end
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (phase % 3 == 0);   // 1,0,0,1,0,0...
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    phase++;
    if (rst_n && tx_valid && tx_ready) rxq.push_back(tx_data);
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  // Reference frame built straight from the frame definition.
  function automatic bq_t frame(input logic [7:0] src, input bq_t pl);
    bq_t f;
    int  len, s;
    len = pl.size();
    s   = src + (len >> 8) + (len & 255);
    f.push_back(8'hAA); f.push_back(8'h44); f.push_back(src);
    f.push_back(8'(len >> 8)); f.push_back(8'(len));
    foreach (pl[i]) begin f.push_back(pl[i]); s += pl[i]; end
    f.push_back(8'(s % 256));
    return f;
  endfunction

  // Hold each byte until the packer takes it; optionally drop req with the last.
  task automatic send_pkt(input logic [7:0] src, input bq_t pl, input bit drop_last);
    int n;
    upload_req    = 1'b1;
    upload_source = src;
    foreach (pl[i]) begin
      upload_valid = 1'b1;
      upload_data  = pl[i];
      if (drop_last && pl.size() >= 2 && i == pl.size() - 1) upload_req = 1'b0;
      n = 0;
      while (!upload_ready && n < 50) begin tick(); n++; end
      if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
      tick();
    end
    upload_valid = 1'b0;
    upload_req   = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input bq_t exp);
    int n;
    n = 0;
    while ((rxq.size() < exp.size() || busy) && n < 300) begin tick(); n++; end
    chk({tag, "_len"}, rxq.size(), exp.size());
    foreach (exp[i])
      if (i < rxq.size()) chk({tag, "_byte"}, {24'd0, rxq[i]}, {24'd0, exp[i]});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    rxq.delete();
  endtask

  initial begin
    bq_t pl, ex;
    int  n, len;
    bit  saw_valid;

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, upload_ready}, 32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Basic frame
    rdy_mode = 0;
    pl = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h05, pl, 1'b0);
    ex = '{8'hAA, 8'h44, 8'h05, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h0E};
    expect_frame("basic", ex);

    // Backpressure
    rdy_mode = 1; phase = 0;
    send_pkt(8'h05, pl, 1'b0);
    expect_frame("bp", ex);

    // Checksum wrap, req dropped with the last byte
    rdy_mode = 0;
    pl = '{8'hFF, 8'hFF};
    send_pkt(8'h01, pl, 1'b1);
    ex = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h01};
    expect_frame("wrap", ex);

    // Empty packet
    saw_valid = 1'b0;
    upload_req = 1'b1; upload_source = 8'h77;
    repeat (4) begin tick(); saw_valid |= tx_valid; end
    upload_req = 1'b0;
    tick();
    chk("empty_busy", {31'd0, busy}, 32'd0);
    repeat (5) begin tick(); saw_valid |= tx_valid; end
    chk("empty_novalid", {31'd0, saw_valid}, 32'd0);
    chk("empty_nobytes", rxq.size(), 32'd0);
    rxq.delete();

    // Randomized packets against the frame model
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, DEPTH);
      pl.delete();
      for (int j = 0; j < len; j++) pl.push_back(8'($urandom));
      rdy_mode = $urandom_range(0, 2);
      send_pkt(8'($urandom), pl, 1'($urandom_range(0, 1)));
      ex = frame(upload_source, pl);
      expect_frame("rand", ex);
    end
    chk("no_ovf_yet", {31'd0, overflow}, 32'd0);

    // Overflow: six bytes presented back to back, only four fit
    rdy_mode = 0;
    upload_req = 1'b1; upload_source = 8'h5A;
    for (int k = 0; k < 6; k++) begin
      upload_valid = 1'b1;
      upload_data  = 8'h10 + 8'(k);
      if (k == 3) chk("ovf_ready_pre", {31'd0, upload_ready}, 32'd1);
      if (k == 4) chk("ovf_ready_full", {31'd0, upload_ready}, 32'd0);
      tick();
    end
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    upload_valid = 1'b0; upload_req = 1'b0;
    pl = '{8'h10, 8'h11, 8'h12, 8'h13};
    ex = frame(8'h5A, pl);
    expect_frame("ovf", ex);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset in the middle of S_DATA
    pl = '{8'h21, 8'h22, 8'h23, 8'h24};
    send_pkt(8'h33, pl, 1'b0);
    n = 0;
    while (rxq.size() < 6 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("midrst_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_ovf",   {31'd0, overflow}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    rxq.delete(); prev_stall = 1'b0;
    repeat (6) tick();
    chk("midrst_silent", rxq.size(), 32'd0);
    pl = '{8'h7F};
    send_pkt(8'h02, pl, 1'b0);
    ex = '{8'hAA, 8'h44, 8'h02, 8'h00, 8'h01, 8'h7F, 8'h82};
    expect_frame("postrst", ex);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
